// File: rtl/microwave_controller_pkg.sv
// Shared definitions for the microwave countdown sequencer.
//   state_t        : controller states
//   MAX_DIGITS     : number of keypad digits the timer holds (M:SS)
//   BCD_MAX        : largest legal keypad digit
//   digit_accepted : true when a keypad digit may be shifted into the timer
package microwave_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MAX_DIGITS = 2'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    function automatic logic digit_accepted(input logic [3:0] digit, input logic [1:0] count);
        return (digit <= BCD_MAX) && (count < MAX_DIGITS);
    endfunction

endpackage

// File: rtl/microwave_controller_button_sync.sv
// Two-flop synchroniser with single-cycle edge pulse for an asynchronous input.
//   clock       : system clock
//   clrn        : asynchronous active-low reset (flops load RESET_LEVEL)
//   raw         : asynchronous input
//   pulse       : one-cycle pulse on the selected edge of the synchronised level
// FALLING=1 selects the falling edge (active-low buttons), otherwise rising edge.
module microwave_controller_button_sync #(
    parameter logic RESET_LEVEL = 1'b0,
    parameter bit   FALLING     = 1'b0
) (
    input  logic clock,
    input  logic clrn,
    input  logic raw,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            meta   <= RESET_LEVEL;
            sync   <= RESET_LEVEL;
            sync_d <= RESET_LEVEL;
        end else begin
            meta   <= raw;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // Pulse is decoded from registered signals only, so the consumer acts on
    // the third clock edge after the raw input changes.
    always_comb begin
        if (FALLING) pulse = sync_d & ~sync;
        else         pulse = sync & ~sync_d;
    end

endmodule

// File: rtl/microwave_controller.sv
// Min:sec countdown sequencer for the microwave oven.
//   clock        in  : system clock, rising edge
//   clrn         in  : asynchronous active-low reset
//   keypad_valid in  : async level, rising edge presents a digit on keypad_data
//   keypad_data  in  : BCD digit, stable while keypad_valid is high
//   startn       in  : async active-low start button
//   stopn        in  : async active-low stop/clear button
//   door_closed  in  : 1 = door closed
//   timer_zero   in  : timer shows 0:00
//   timer_loadn  out : active-low one-cycle shift-load strobe
//   timer_clrn   out : active-low timer clear
//   timer_en     out : one-cycle decrement enable (once per TICK_DIV cycles in COOK)
//   timer_data   out : digit presented with timer_loadn
//   mag_on       out : magnetron enable
//   done         out : cook-complete indicator, high for DONE_CYCLES cycles
// All outputs are registered.
module microwave_controller
    import microwave_controller_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned DONE_CYCLES = 100
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_data,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_en,
    output logic [3:0] timer_data,
    output logic       mag_on,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_CYCLES - 1);

    logic key_p;
    logic start_p;
    logic stop_p;
    logic door_meta;
    logic door_sync;

    state_t        state,        state_nxt;
    logic [1:0]    digit_cnt,    digit_cnt_nxt;
    logic [PW-1:0] prescaler,    prescaler_nxt;
    logic [DW-1:0] done_cnt,     done_cnt_nxt;
    logic          loadn_nxt;
    logic          clrn_nxt;
    logic          en_nxt;
    logic [3:0]    data_nxt;
    logic          mag_nxt;
    logic          done_nxt;
    logic          key_ok;

    microwave_controller_button_sync #(
        .RESET_LEVEL (1'b0),
        .FALLING     (1'b0)
    ) u_key_sync (
        .clock (clock),
        .clrn  (clrn),
        .raw   (keypad_valid),
        .pulse (key_p)
    );

    microwave_controller_button_sync #(
        .RESET_LEVEL (1'b1),
        .FALLING     (1'b1)
    ) u_start_sync (
        .clock (clock),
        .clrn  (clrn),
        .raw   (startn),
        .pulse (start_p)
    );

    microwave_controller_button_sync #(
        .RESET_LEVEL (1'b1),
        .FALLING     (1'b1)
    ) u_stop_sync (
        .clock (clock),
        .clrn  (clrn),
        .raw   (stopn),
        .pulse (stop_p)
    );

    // Door only needs its level; resets to "open" so nothing can cook
    // before the synchroniser has filled.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            door_meta <= 1'b0;
            door_sync <= 1'b0;
        end else begin
            door_meta <= door_closed;
            door_sync <= door_meta;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state       <= S_IDLE;
            digit_cnt   <= '0;
            prescaler   <= '0;
            done_cnt    <= '0;
            timer_loadn <= 1'b1;
            timer_clrn  <= 1'b0;
            timer_en    <= 1'b0;
            timer_data  <= '0;
            mag_on      <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            digit_cnt   <= digit_cnt_nxt;
            prescaler   <= prescaler_nxt;
            done_cnt    <= done_cnt_nxt;
            timer_loadn <= loadn_nxt;
            timer_clrn  <= clrn_nxt;
            timer_en    <= en_nxt;
            timer_data  <= data_nxt;
            mag_on      <= mag_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        digit_cnt_nxt = digit_cnt;
        prescaler_nxt = prescaler;
        done_cnt_nxt  = done_cnt;
        loadn_nxt     = 1'b1;
        clrn_nxt      = 1'b1;
        en_nxt        = 1'b0;
        data_nxt      = timer_data;
        key_ok        = key_p && digit_accepted(keypad_data, digit_cnt);

        unique case (state)
            S_IDLE: begin
                if (key_ok) begin
                    data_nxt      = keypad_data;
                    loadn_nxt     = 1'b0;
                    digit_cnt_nxt = digit_cnt + 2'd1;
                    state_nxt     = S_ENTRY;
                end
            end

            S_ENTRY: begin
                // stop wins over a simultaneous start or key
                if (stop_p) begin
                    clrn_nxt      = 1'b0;
                    digit_cnt_nxt = '0;
                    state_nxt     = S_IDLE;
                end else if (start_p && door_sync && !timer_zero) begin
                    prescaler_nxt = '0;
                    state_nxt     = S_COOK;
                end else if (key_ok) begin
                    data_nxt      = keypad_data;
                    loadn_nxt     = 1'b0;
                    digit_cnt_nxt = digit_cnt + 2'd1;
                end
            end

            S_COOK: begin
                // timer_zero beats door open beats stop
                if (timer_zero) begin
                    done_cnt_nxt = '0;
                    state_nxt    = S_DONE;
                end else if (!door_sync || stop_p) begin
                    state_nxt = S_PAUSE;
                end else if (prescaler == PRE_LAST) begin
                    prescaler_nxt = '0;
                    en_nxt        = 1'b1;
                end else begin
                    prescaler_nxt = prescaler + 1'b1;
                end
            end

            S_PAUSE: begin
                // prescaler is left untouched so a resume keeps the partial second
                if (stop_p) begin
                    clrn_nxt      = 1'b0;
                    digit_cnt_nxt = '0;
                    state_nxt     = S_IDLE;
                end else if (start_p && door_sync) begin
                    state_nxt = S_COOK;
                end
            end

            S_DONE: begin
                if (stop_p || done_cnt == DONE_LAST) begin
                    digit_cnt_nxt = '0;
                    state_nxt     = S_IDLE;
                end else begin
                    done_cnt_nxt = done_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Moore outputs follow the state being entered so they line up with it
        mag_nxt  = (state_nxt == S_COOK);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_microwave_controller.sv
module tb_microwave_controller;

    logic       clock = 1'b0;
    logic       clrn;
    logic       keypad_valid;
    logic [3:0] keypad_data;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       timer_zero;
    logic       timer_loadn;
    logic       timer_clrn;
    logic       timer_en;
    logic [3:0] timer_data;
    logic       mag_on;
    logic       done;

    int tests = 0;
    int fails = 0;

    microwave_controller #(
        .TICK_DIV    (4),
        .DONE_CYCLES (8)
    ) dut (
        .clock        (clock),
        .clrn         (clrn),
        .keypad_valid (keypad_valid),
        .keypad_data  (keypad_data),
        .startn       (startn),
        .stopn        (stopn),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .timer_loadn  (timer_loadn),
        .timer_clrn   (timer_clrn),
        .timer_en     (timer_en),
        .timer_data   (timer_data),
        .mag_on       (mag_on),
        .done         (done)
    );

    always #5 clock = ~clock;

    // ---------------- timer model (M:SS in BCD) ----------------
    logic [11:0] tmr = '0;

    function automatic logic [11:0] bcd_dec(input logic [11:0] t);
        logic [3:0] m, st, so;
        m = t[11:8]; st = t[7:4]; so = t[3:0];
        if (so != 4'd0) so = so - 4'd1;
        else if (st != 4'd0) begin st = st - 4'd1; so = 4'd9; end
        else if (m != 4'd0) begin m = m - 4'd1; st = 4'd5; so = 4'd9; end
        return {m, st, so};
    endfunction

    always @(posedge clock) begin
        if (!timer_clrn)       tmr <= '0;
        else if (!timer_loadn) tmr <= {tmr[7:0], timer_data};
        else if (timer_en)     tmr <= bcd_dec(tmr);
    end

    assign timer_zero = (tmr == 12'h000);

    // ---------------- output monitor ----------------
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   act_log[$];
    int   en_log[$];
    int   overlap_n = 0;
    int   en_outside_n = 0;
    int   clrn_low_n = 0;
    int   mag_rise_n = 0;
    int   mag_rise_cyc = 0;
    int   mag_fall_cyc = 0;
    int   done_hi_n = 0;
    int   done_rise_cyc = 0;
    logic mag_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(negedge clock) begin
        if (!timer_loadn) act_log.push_back(int'(timer_data));
        if (!timer_loadn && !timer_clrn) overlap_n++;
        if (!timer_clrn && clrn) clrn_low_n++;
        if (timer_en) begin
            en_log.push_back(cyc);
            if (!mag_on) en_outside_n++;
        end
        if (mag_on && !mag_prev) begin mag_rise_n++; mag_rise_cyc = cyc; end
        if (!mag_on && mag_prev) mag_fall_cyc = cyc;
        if (done) done_hi_n++;
        if (done && !done_prev) done_rise_cyc = cyc;
        mag_prev  = mag_on;
        done_prev = done;
    end

    // ---------------- helpers ----------------
    int exp_q[$];

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        keypad_data  = d;
        keypad_valid = 1'b1;
        tick(6);
        keypad_valid = 1'b0;
        tick(6);
    endtask

    task automatic press_btn(input bit do_start, input bit do_stop);
        if (do_start) startn = 1'b0;
        if (do_stop)  stopn  = 1'b0;
        tick(4);
        startn = 1'b1;
        stopn  = 1'b1;
        tick(4);
    endtask

    task automatic key_step(input logic [3:0] d, input bit accept, input logic [11:0] disp);
        int n0;
        int e;
        n0 = act_log.size();
        if (accept) exp_q.push_back(int'(d));
        press_key(d);
        check("load_pulses", act_log.size() - n0, accept ? 1 : 0);
        if (accept) begin
            e = exp_q.pop_front();
            if (act_log.size() > n0) check("load_data", act_log[n0], e);
        end
        check("timer_display", int'(tmr), int'(disp));
    endtask

    typedef struct {
        logic [3:0]  digit;
        bit          accept;
        logic [11:0] disp;
    } key_vec_t;

    key_vec_t kv [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int k, p, e0, e1, r0, c0, d0;

        kv[0] = '{4'd12, 1'b0, 12'h000};
        kv[1] = '{4'd1,  1'b1, 12'h001};
        kv[2] = '{4'd3,  1'b1, 12'h013};
        kv[3] = '{4'd0,  1'b1, 12'h130};
        kv[4] = '{4'd5,  1'b0, 12'h130};

        clrn = 1'b0; keypad_valid = 1'b0; keypad_data = '0;
        startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        tick(3);
        check("rst_loadn", timer_loadn, 1);
        check("rst_clrn",  timer_clrn,  0);
        check("rst_en",    timer_en,    0);
        check("rst_data",  timer_data,  0);
        check("rst_mag",   mag_on,      0);
        check("rst_done",  done,        0);
        @(negedge clock); #1; clrn = 1'b1;
        tick(1);
        check("clrn_release", timer_clrn, 1);
        tick(4);

        // digit entry: invalid digit, three digits, fourth ignored
        for (int i = 0; i < 5; i++) key_step(kv[i].digit, kv[i].accept, kv[i].disp);

        // stop in ENTRY clears
        c0 = clrn_low_n;
        press_btn(1'b0, 1'b1);
        check("entry_stop_clear", clrn_low_n - c0, 1);
        check("entry_stop_timer", int'(tmr), 0);

        // 0:02 full cook
        key_step(4'd0, 1'b1, 12'h000);
        key_step(4'd0, 1'b1, 12'h000);
        key_step(4'd2, 1'b1, 12'h002);
        e0 = en_log.size(); r0 = mag_rise_n; d0 = done_hi_n;
        k = cyc;
        press_btn(1'b1, 1'b0);
        tick(30);
        check("cook_rise", mag_rise_n - r0, 1);
        check("start_latency", mag_rise_cyc - k, 3);
        check("tick_count", en_log.size() - e0, 2);
        if (en_log.size() - e0 >= 2) begin
            check("first_tick", en_log[e0] - mag_rise_cyc, 4);
            check("tick_period", en_log[e0+1] - en_log[e0], 4);
            check("zero_to_magoff", mag_fall_cyc - en_log[e0+1], 2);
        end
        check("done_len", done_hi_n - d0, 8);
        check("done_with_magoff", done_rise_cyc - mag_fall_cyc, 0);
        check("after_done_outputs", {30'd0, done, mag_on}, 0);
        check("after_done_timer", int'(tmr), 0);

        // door opens with prescaler at 2, then resume
        key_step(4'd1, 1'b1, 12'h001);
        key_step(4'd0, 1'b1, 12'h010);
        key_step(4'd0, 1'b1, 12'h100);
        e0 = en_log.size();
        startn = 1'b0;
        tick(3);
        door_closed = 1'b0;
        startn = 1'b1;
        tick(10);
        check("door_pause_latency", mag_fall_cyc - mag_rise_cyc, 3);
        check("door_no_tick", en_log.size() - e0, 0);
        check("door_mag_off", mag_on, 0);
        door_closed = 1'b1;
        tick(4);
        r0 = mag_rise_n;
        k = cyc;
        press_btn(1'b1, 1'b0);
        check("resume_rise", mag_rise_n - r0, 1);
        check("resume_latency", mag_rise_cyc - k, 3);
        check("resume_ticks", en_log.size() - e0, 1);
        if (en_log.size() > e0) check("partial_second", en_log[e0] - mag_rise_cyc, 2);
        check("resume_timer", int'(tmr), 12'h059);

        // stop in COOK pauses, stop in PAUSE clears
        p = cyc;
        press_btn(1'b0, 1'b1);
        check("stop_pause_latency", mag_fall_cyc - p, 3);
        e1 = en_log.size();
        tick(8);
        check("pause_frozen", en_log.size() - e1, 0);
        check("pause_mag_off", mag_on, 0);
        c0 = clrn_low_n;
        press_btn(1'b0, 1'b1);
        check("pause_stop_clear", clrn_low_n - c0, 1);
        check("pause_stop_timer", int'(tmr), 0);
        key_step(4'd12, 1'b0, 12'h000);

        // start+stop together in ENTRY, then start at 0:00
        key_step(4'd4, 1'b1, 12'h004);
        key_step(4'd5, 1'b1, 12'h045);
        c0 = clrn_low_n; r0 = mag_rise_n;
        press_btn(1'b1, 1'b1);
        check("both_clear", clrn_low_n - c0, 1);
        check("both_no_cook", mag_rise_n - r0, 0);
        check("both_timer", int'(tmr), 0);
        key_step(4'd0, 1'b1, 12'h000);
        press_btn(1'b1, 1'b0);
        tick(6);
        check("zero_start_ignored", mag_rise_n - r0, 0);
        press_btn(1'b0, 1'b1);

        // asynchronous reset mid-cook
        key_step(4'd1, 1'b1, 12'h001);
        key_step(4'd0, 1'b1, 12'h010);
        key_step(4'd7, 1'b1, 12'h107);
        press_btn(1'b1, 1'b0);
        check("cook_before_reset", mag_on, 1);
        @(negedge clock); #2;
        clrn = 1'b0;
        #1;
        check("async_mag", mag_on, 0);
        check("async_loadn", timer_loadn, 1);
        check("async_clrn", timer_clrn, 0);
        check("async_en", timer_en, 0);
        check("async_data", timer_data, 0);
        check("async_done", done, 0);
        @(negedge clock); #1; clrn = 1'b1;
        tick(1);
        check("async_release", timer_clrn, 1);

        check("loadn_clrn_overlap", overlap_n, 0);
        check("en_outside_cook", en_outside_n, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
